operand_load_ctrl: RTL and testbench

OPERAND_LOAD_CTRL -- requirements
Module: operand_load_ctrl

---
 rtl/operand_load_ctrl_pkg.sv | 15 +
 rtl/operand_load_ctrl_sat.sv | 23 ++
 rtl/operand_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_operand_load_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_load_ctrl_pkg.sv
// Shared definitions for the operand load controller: FSM encoding and default geometry.
package operand_load_ctrl_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_RUN_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_KICK = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/operand_load_ctrl_sat.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < WIDTH'(MAX))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/operand_load_ctrl.sv
// Accepts a load command, streams operand words into the buffer, then kicks the
// valid pipeline and holds load_ready until the pipeline has run (or timed out).
module operand_load_ctrl
    import operand_load_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_W      = DEF_DATA_W,
    parameter  int unsigned DEPTH       = DEF_DEPTH,
    parameter  int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              cmd_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    output logic              load_ready,
    input  logic              pipe_busy,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(RUN_TIMEOUT + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  len, len_n;
    logic              seen_busy, seen_busy_n;
    logic              cmd_ready_n, in_ready_n, wr_en_n, start_n, load_ready_n, err_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic [CNT_W-1:0]  word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              word_clr, word_inc, tmo_clr, tmo_inc;
    logic              cmd_fire, in_fire, len_legal;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_fire   = in_valid && in_ready;
    assign len_legal = (cmd_len != '0) && (cmd_len <= CNT_W'(DEPTH));

    sat_counter #(.WIDTH(CNT_W), .MAX(DEPTH)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (word_clr),
        .inc   (word_inc),
        .count (word_cnt)
    );

    sat_counter #(.WIDTH(TMO_W), .MAX(RUN_TIMEOUT)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr),
        .inc   (tmo_inc),
        .count (tmo_cnt)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            seen_busy  <= 1'b0;
            cmd_ready  <= 1'b0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            start      <= 1'b0;
            load_ready <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            seen_busy  <= seen_busy_n;
            cmd_ready  <= cmd_ready_n;
            in_ready   <= in_ready_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            start      <= start_n;
            load_ready <= load_ready_n;
            err        <= err_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n      = state;
        len_n        = len;
        seen_busy_n  = seen_busy;
        cmd_ready_n  = 1'b0;
        in_ready_n   = 1'b0;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        start_n      = 1'b0;
        load_ready_n = 1'b0;
        err_n        = 1'b0;
        word_clr     = 1'b0;
        word_inc     = 1'b0;
        tmo_clr      = 1'b0;
        tmo_inc      = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready_n = 1'b1;
                word_clr    = 1'b1;
                tmo_clr     = 1'b1;
                seen_busy_n = 1'b0;
                if (cmd_fire) begin
                    if (len_legal) begin
                        len_n       = cmd_len;
                        cmd_ready_n = 1'b0;
                        in_ready_n  = 1'b1;
                        state_n     = ST_LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                in_ready_n = 1'b1;
                if (in_fire) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = ADDR_W'(word_cnt);
                    wr_data_n = in_data;
                    word_inc  = 1'b1;
                    // Last word: close the input this very edge so nothing extra slips in
                    if (word_cnt == (len - CNT_W'(1))) begin
                        in_ready_n = 1'b0;
                        state_n    = ST_KICK;
                    end
                end
            end
            ST_KICK: begin
                start_n      = 1'b1;
                load_ready_n = 1'b1;
                tmo_inc      = 1'b1;
                state_n      = ST_RUN;
            end
            ST_RUN: begin
                load_ready_n = 1'b1;
                if (seen_busy) begin
                    if (!pipe_busy) begin
                        load_ready_n = 1'b0;
                        cmd_ready_n  = 1'b1;
                        state_n      = ST_IDLE;
                    end
                end else if (pipe_busy) begin
                    seen_busy_n = 1'b1;
                end else if (tmo_cnt >= TMO_W'(RUN_TIMEOUT - 1)) begin
                    err_n        = 1'b1;
                    load_ready_n = 1'b0;
                    cmd_ready_n  = 1'b1;
                    state_n      = ST_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Bench for operand_load_ctrl: timestamp-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_operand_load_ctrl;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned RUN_TIMEOUT = 64;
    localparam int unsigned ADDR_W      = $clog2(DEPTH);

    logic              clk, rst_n;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W:0]   cmd_len;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start, load_ready, pipe_busy, err;

    operand_load_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .RUN_TIMEOUT (RUN_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .load_ready (load_ready),
        .pipe_busy  (pipe_busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Model: a load owes cmd_len words; the kick happens the cycle the last write
    // appears; start follows one cycle later; the pipeline is watched from then on.
    bit                mv = 1'b0;
    bit                m_idle;
    int                m_owed, m_addr, m_kick;
    bit                m_run, m_seen;
    logic              e_cmd_ready, e_in_ready, e_wr_en, e_start, e_load_ready, e_err;
    logic [ADDR_W-1:0] e_wr_addr;
    logic [DATA_W-1:0] e_wr_data;

    always @(posedge clk) begin : model
        bit take_cmd, take_word;
        cyc = cyc + 1;
        take_cmd  = cmd_valid && e_cmd_ready;
        take_word = in_valid && e_in_ready;
        if (!rst_n) begin
            mv = 1'b1; m_idle = 1'b1; m_owed = 0; m_addr = 0; m_run = 1'b0; m_seen = 1'b0;
            e_cmd_ready = 0; e_in_ready = 0; e_wr_en = 0; e_start = 0; e_load_ready = 0;
            e_err = 0; e_wr_addr = '0; e_wr_data = '0;
        end else if (mv) begin
            e_wr_en = 0; e_start = 0; e_err = 0;
            if (m_idle) begin
                if (take_cmd) begin
                    if (int'(cmd_len) >= 1 && int'(cmd_len) <= int'(DEPTH)) begin
                        m_idle = 1'b0; m_owed = int'(cmd_len); m_addr = 0;
                    end else begin
                        e_err = 1;
                    end
                end
            end else if (m_owed > 0) begin
                if (take_word) begin
                    e_wr_en = 1; e_wr_addr = ADDR_W'(m_addr); e_wr_data = in_data;
                    m_addr++; m_owed--;
                    if (m_owed == 0) begin
                        m_kick = cyc; m_run = 1'b1; m_seen = 1'b0;
                    end
                end
            end else if (m_run) begin
                if (cyc == m_kick + 1) begin
                    e_start = 1;
                end else begin
                    if (m_seen) begin
                        if (!pipe_busy) begin m_run = 1'b0; m_idle = 1'b1; end
                    end else if (pipe_busy) begin
                        m_seen = 1'b1;
                    end else if (cyc >= m_kick + int'(RUN_TIMEOUT)) begin
                        e_err = 1; m_run = 1'b0; m_idle = 1'b1;
                    end
                end
            end
            e_cmd_ready  = m_idle;
            e_in_ready   = !m_idle && (m_owed > 0);
            e_load_ready = m_run && (cyc >= m_kick + 1);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mv) begin
            chk("cmd_ready", cmd_ready, e_cmd_ready);
            chk("in_ready", in_ready, e_in_ready);
            chk("wr_en", wr_en, e_wr_en);
            if (e_wr_en) begin
                chk("wr_addr", wr_addr, e_wr_addr);
                chk("wr_data", wr_data, e_wr_data);
            end
            chk("start", start, e_start);
            chk("load_ready", load_ready, e_load_ready);
            chk("err", err, e_err);
        end
    end

    // Event recorder for the directed expectations
    int wa_q[$];
    int wd_q[$];
    int start_cnt = 0, start_cyc = 0, err_cnt = 0, err_cyc = 0, lr_rise = 0, lr_fall = 0;
    bit lr_prev = 1'b0;

    always @(negedge clk) begin
        if (mv) begin
            if (wr_en === 1'b1) begin
                wa_q.push_back(int'(wr_addr));
                wd_q.push_back(int'(wr_data));
            end
            if (start === 1'b1) begin start_cnt++; start_cyc = cyc; end
            if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
            if (load_ready === 1'b1 && !lr_prev) lr_rise = cyc;
            if (load_ready === 1'b0 && lr_prev) lr_fall = cyc;
            lr_prev = (load_ready === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input int len);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("cmd_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = (ADDR_W+1)'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int base, input int step, input int gap,
                              output int last);
        int t;
        last = 0;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                in_valid = 1'b0;
                tick(gap);
            end
            t = 0;
            while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            chk("in_wait", in_ready, 1);
            in_valid = 1'b1;
            in_data  = DATA_W'(base + i * step);
            last     = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (start !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("start_wait", start, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("idle_wait", cmd_ready, 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int last, busy_fall, s0, e0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
        in_data = '0; pipe_busy = 1'b0;

        // Reset
        tick(3);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_load_ready", load_ready, 0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Test 1 + 3: four back-to-back words, then a 4-cycle busy pipeline
        wa_q.delete(); wd_q.delete(); s0 = start_cnt;
        send_cmd(4);
        send_words(4, 'h11, 'h11, 0, last);
        in_valid = 1'b1; in_data = 8'h55;
        tick(1);
        in_valid = 1'b0;
        wait_start();
        pipe_busy = 1'b1;
        tick(4);
        pipe_busy = 1'b0;
        busy_fall = cyc;
        wait_idle();
        tick(2);
        chk("t1_nwrites", wa_q.size(), 4);
        if (wa_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", wa_q[i], i);
                chk("t1_data", wd_q[i], 'h11 * (i + 1));
            end
        end
        chk("t1_nstart", start_cnt - s0, 1);
        chk("t1_start_lat", start_cyc - last, 2);
        chk("t1_lr_rise", lr_rise, start_cyc);
        chk("t3_lr_fall", lr_fall - busy_fall, 1);
        chk("t3_cmd_ready", cmd_ready, 1);

        // Test 2: three words with 2-cycle gaps
        wa_q.delete(); wd_q.delete(); s0 = start_cnt;
        send_cmd(3);
        send_words(3, 'h30, 1, 2, last);
        wait_start();
        pipe_busy = 1'b1;
        tick(1);
        pipe_busy = 1'b0;
        wait_idle();
        tick(2);
        chk("t2_nwrites", wa_q.size(), 3);
        if (wa_q.size() == 3) chk("t2_last_data", wd_q[2], 'h32);
        chk("t2_start_lat", start_cyc - last, 2);
        chk("t2_nstart", start_cnt - s0, 1);

        // Test 4: illegal lengths
        e0 = err_cnt;
        send_cmd(0);
        tick(2);
        chk("t4_err_len0", err_cnt - e0, 1);
        chk("t4_in_ready0", in_ready, 0);
        send_cmd(17);
        tick(2);
        chk("t4_err_len17", err_cnt - e0, 2);
        chk("t4_cmd_ready", cmd_ready, 1);

        // Test 5: full-depth load, pipeline never starts
        wa_q.delete(); wd_q.delete(); e0 = err_cnt;
        send_cmd(16);
        send_words(16, 1, 3, 0, last);
        wait_start();
        begin
            int t;
            t = 0;
            while (err !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            chk("t5_err_wait", err, 1);
        end
        tick(2);
        chk("t5_nwrites", wa_q.size(), 16);
        if (wa_q.size() == 16) begin
            chk("t5_addr15", wa_q[15], 15);
            chk("t5_data15", wd_q[15], 46);
        end
        chk("t5_err_cnt", err_cnt - e0, 1);
        chk("t5_timeout", err_cyc - (start_cyc - 1), 64);
        chk("t5_idle", cmd_ready, 1);

        // Test 6: reset after the second of four words
        s0 = start_cnt; e0 = err_cnt;
        send_cmd(4);
        send_words(2, 'h70, 1, 0, last);
        rst_n = 1'b0;
        tick(2);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_wr_en", wr_en, 0);
        rst_n = 1'b1;
        tick(3);
        chk("t6_no_start", start_cnt - s0, 0);
        chk("t6_no_err", err_cnt - e0, 0);
        wa_q.delete(); wd_q.delete();
        send_cmd(2);
        send_words(2, 'hA1, 1, 0, last);
        wait_start();
        pipe_busy = 1'b1;
        tick(1);
        pipe_busy = 1'b0;
        wait_idle();
        tick(3);
        chk("t6_nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("t6_addr0", wa_q[0], 0);
            chk("t6_data0", wd_q[0], 'hA1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
